// File: rtl/lc4_alu_ctl_pkg.sv
// Shared LC4 ALU-control codes, opcode nibbles, immediate widths and fit helpers.
// Used by the encoder today and intended for the decoder rewrite as well.
package lc4_alu_ctl_pkg;

   localparam logic [15:0] CTL_ADD     = 16'd0;
   localparam logic [15:0] CTL_MUL     = 16'd1;
   localparam logic [15:0] CTL_SUB     = 16'd2;
   localparam logic [15:0] CTL_DIV     = 16'd3;
   localparam logic [15:0] CTL_MOD     = 16'd4;
   localparam logic [15:0] CTL_ADDI    = 16'd6;
   localparam logic [15:0] CTL_AND     = 16'd8;
   localparam logic [15:0] CTL_NOT     = 16'd9;
   localparam logic [15:0] CTL_OR      = 16'd10;
   localparam logic [15:0] CTL_XOR     = 16'd11;
   localparam logic [15:0] CTL_ANDI    = 16'd12;
   localparam logic [15:0] CTL_CMP     = 16'd16;
   localparam logic [15:0] CTL_CMPU    = 16'd17;
   localparam logic [15:0] CTL_CMPI    = 16'd18;
   localparam logic [15:0] CTL_CMPIU   = 16'd19;
   localparam logic [15:0] CTL_SLL     = 16'd24;
   localparam logic [15:0] CTL_SRA     = 16'd25;
   localparam logic [15:0] CTL_SRL     = 16'd26;
   localparam logic [15:0] CTL_CONST   = 16'd32;
   localparam logic [15:0] CTL_HICONST = 16'd33;
   localparam logic [15:0] CTL_JMP     = 16'd34;
   localparam logic [15:0] CTL_RTI     = 16'd36;

   localparam logic [3:0] OPC_ARITH   = 4'b0001;
   localparam logic [3:0] OPC_CMP     = 4'b0010;
   localparam logic [3:0] OPC_LOGIC   = 4'b0101;
   localparam logic [3:0] OPC_RTI     = 4'b1000;
   localparam logic [3:0] OPC_CONST   = 4'b1001;
   localparam logic [3:0] OPC_SHIFT   = 4'b1010;
   localparam logic [3:0] OPC_JMP     = 4'b1100;
   localparam logic [3:0] OPC_HICONST = 4'b1101;

   localparam int IMM4_W  = 4;
   localparam int IMM5_W  = 5;
   localparam int IMM7_W  = 7;
   localparam int IMM8_W  = 8;
   localparam int IMM9_W  = 9;

   typedef struct packed {
      logic        err;
      logic        ovf;
      logic [15:0] insn;
   } enc_word_t;

   // Signed fit: every bit from the field's sign bit upward must agree.
   function automatic logic imm_fits_s(input logic [10:0] imm, input int w);
      logic [10:0] hi;
      hi = 11'h7FF << (w - 1);
      return ((imm & hi) == 11'h000) || ((imm & hi) == hi);
   endfunction

   function automatic logic imm_fits_u(input logic [10:0] imm, input int w);
      logic [10:0] hi;
      hi = 11'h7FF << w;
      return (imm & hi) == 11'h000;
   endfunction

endpackage

// File: rtl/lc4_insn_fifo.sv
// Small FIFO with wrap-bit pointers; head data and valid are registered so the
// consumer side sees flop outputs only.
module lc4_insn_fifo
   import lc4_alu_ctl_pkg::*;
#(
   parameter int WIDTH = 18,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] head_reg, head_next;
   logic             valid_reg, valid_next;
   logic             do_wr, do_rd;

   assign full        = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
   assign do_wr       = wr_en & ~full;
   assign do_rd       = rd_en & valid_reg;
   assign wr_ptr_next = wr_ptr_reg + (AW+1)'(do_wr);
   assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_rd);
   assign valid_next  = (wr_ptr_next != rd_ptr_next);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            mem[gi] <= '0;
         else if (do_wr && wr_ptr_reg[AW-1:0] == AW'(gi))
            mem[gi] <= wr_data;
      end
   end

   // The slot being written can only be the next head when it becomes the sole entry.
   always_comb begin
      head_next = '0;
      if (valid_next) begin
         if (do_wr && wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])
            head_next = wr_data;
         else
            head_next = mem[rd_ptr_next[AW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         head_reg   <= '0;
         valid_reg  <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         head_reg   <= head_next;
         valid_reg  <= valid_next;
      end
   end

   assign rd_data  = head_reg;
   assign rd_valid = valid_reg;

endmodule

// File: rtl/lc4_insn_encoder.sv
// Encodes an ALU-control code plus operand fields into a canonical LC4 word and
// buffers the result in a small FIFO with valid/ready on both sides.
module lc4_insn_encoder
   import lc4_alu_ctl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_ctl,
   input  logic [2:0]  i_rd,
   input  logic [2:0]  i_rs,
   input  logic [2:0]  i_rt,
   input  logic [10:0] i_imm,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_insn,
   output logic        o_err,
   output logic        o_ovf,
   output logic [15:0] o_count
);

   // Sub-op fields come straight from the low bits of the control code, since
   // each family was numbered consecutively from an aligned base.
   function automatic enc_word_t encode(input logic [15:0] ctl, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [10:0] imm);
      enc_word_t w;
      w = '0;
      case (ctl)
         CTL_ADD, CTL_MUL, CTL_SUB, CTL_DIV:
            w.insn = {OPC_ARITH, rd, rs, ctl[2:0], rt};
         CTL_ADDI: begin
            w.insn = {OPC_ARITH, rd, rs, 1'b1, imm[IMM5_W-1:0]};
            w.ovf  = ~imm_fits_s(imm, IMM5_W);
         end
         CTL_AND, CTL_NOT, CTL_OR, CTL_XOR:
            w.insn = {OPC_LOGIC, rd, rs, ctl[2:0], rt};
         CTL_ANDI: begin
            w.insn = {OPC_LOGIC, rd, rs, 1'b1, imm[IMM5_W-1:0]};
            w.ovf  = ~imm_fits_s(imm, IMM5_W);
         end
         CTL_CMP, CTL_CMPU:
            w.insn = {OPC_CMP, rs, 1'b0, ctl[0], 4'b0000, rt};
         CTL_CMPI: begin
            w.insn = {OPC_CMP, rs, 2'b10, imm[IMM7_W-1:0]};
            w.ovf  = ~imm_fits_s(imm, IMM7_W);
         end
         CTL_CMPIU: begin
            w.insn = {OPC_CMP, rs, 2'b11, imm[IMM7_W-1:0]};
            w.ovf  = ~imm_fits_u(imm, IMM7_W);
         end
         CTL_SLL, CTL_SRA, CTL_SRL: begin
            w.insn = {OPC_SHIFT, rd, rs, ctl[1:0], imm[IMM4_W-1:0]};
            w.ovf  = ~imm_fits_u(imm, IMM4_W);
         end
         CTL_MOD:
            w.insn = {OPC_SHIFT, rd, rs, 2'b11, 1'b0, rt};
         CTL_CONST: begin
            w.insn = {OPC_CONST, rd, imm[IMM9_W-1:0]};
            w.ovf  = ~imm_fits_s(imm, IMM9_W);
         end
         CTL_HICONST: begin
            w.insn = {OPC_HICONST, rd, 1'b1, imm[IMM8_W-1:0]};
            w.ovf  = ~imm_fits_u(imm, IMM8_W);
         end
         CTL_JMP:
            w.insn = {OPC_JMP, 1'b1, imm};
         CTL_RTI:
            w.insn = {OPC_RTI, 12'h000};
         default:
            w.err = 1'b1;
      endcase
      return w;
   endfunction

   enc_word_t enc_word, head_word;
   logic      ready_en_reg;
   logic      fifo_full;
   logic      push, pop;
   logic [15:0] count_reg;

   assign enc_word = encode(i_ctl, i_rd, i_rs, i_rt, i_imm);
   assign o_ready  = ready_en_reg & ~fifo_full;
   assign push     = i_valid & o_ready;
   assign pop      = o_valid & i_ready;

   lc4_insn_fifo #(
      .WIDTH($bits(enc_word_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (enc_word),
      .full    (fifo_full),
      .rd_en   (i_ready),
      .rd_data (head_word),
      .rd_valid(o_valid)
   );

   // Holds o_ready low until the first clock edge after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_reg <= 1'b0;
         count_reg    <= '0;
      end else begin
         ready_en_reg <= 1'b1;
         if (pop)
            count_reg <= count_reg + 16'd1;
      end
   end

   assign o_insn  = head_word.insn;
   assign o_err   = head_word.err;
   assign o_ovf   = head_word.ovf;
   assign o_count = count_reg;

endmodule

// File: tb/tb_lc4_insn_encoder.sv
// Directed bench for lc4_insn_encoder: encode table, overflow flags, FIFO
// back-pressure and asynchronous reset.
module tb_lc4_insn_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_ready;
   logic [15:0] i_ctl;
   logic [2:0]  i_rd, i_rs, i_rt;
   logic [10:0] i_imm;
   logic        o_ready, o_valid, o_err, o_ovf;
   logic [15:0] o_insn, o_count;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count = 16'd0;

   always #5 clk = ~clk;

   lc4_insn_encoder #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_ctl(i_ctl), .i_rd(i_rd), .i_rs(i_rs), .i_rt(i_rt), .i_imm(i_imm),
      .o_valid(o_valid), .i_ready(i_ready), .o_insn(o_insn),
      .o_err(o_err), .o_ovf(o_ovf), .o_count(o_count)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [15:0] ctl, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [10:0] imm);
      i_ctl   = ctl;
      i_rd    = rd;
      i_rs    = rs;
      i_rt    = rt;
      i_imm   = imm;
      i_valid = 1'b1;
   endtask

   // One request with the consumer always ready: accept, word visible one cycle later, then drained.
   task automatic xact(input string tag, input logic [15:0] ctl, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [10:0] imm,
                       input logic [15:0] e_insn, input logic e_err, input logic e_ovf);
      @(negedge clk);
      drive(ctl, rd, rs, rt, imm);
      chk({tag, "_ready"}, {15'd0, o_ready}, 16'd1);
      @(negedge clk);
      i_valid = 1'b0;
      chk({tag, "_valid"}, {15'd0, o_valid}, 16'd1);
      chk({tag, "_insn"}, o_insn, e_insn);
      chk({tag, "_err"}, {15'd0, o_err}, {15'd0, e_err});
      chk({tag, "_ovf"}, {15'd0, o_ovf}, {15'd0, e_ovf});
      exp_count = exp_count + 16'd1;
      @(negedge clk);
      chk({tag, "_drained"}, {15'd0, o_valid}, 16'd0);
      chk({tag, "_count"}, o_count, exp_count);
      $display("xact %s ctl=%0d -> insn=%h err=%b ovf=%b count=%0d", tag, ctl, o_insn, o_err, o_ovf, o_count);
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
      i_ctl = '0; i_rd = '0; i_rs = '0; i_rt = '0; i_imm = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {15'd0, o_ready}, 16'd0);
      chk("rst_valid", {15'd0, o_valid}, 16'd0);
      chk("rst_insn", o_insn, 16'h0000);
      chk("rst_count", o_count, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {15'd0, o_ready}, 16'd1);

      // Encode table and immediate fit
      xact("add",     16'd0,  3'd1, 3'd2, 3'd3, 11'h000, 16'h1283, 1'b0, 1'b0);
      xact("addi_m1", 16'd6,  3'd1, 3'd2, 3'd0, 11'h7FF, 16'h12BF, 1'b0, 1'b0);
      xact("addi_16", 16'd6,  3'd1, 3'd2, 3'd0, 11'd16,  16'h12B0, 1'b0, 1'b1);
      xact("cmpiu",   16'd19, 3'd0, 3'd3, 3'd0, 11'd100, 16'h27E4, 1'b0, 1'b0);
      xact("cmpiu_o", 16'd19, 3'd0, 3'd3, 3'd0, 11'd128, 16'h2780, 1'b0, 1'b1);
      xact("illegal", 16'd5,  3'd7, 3'd7, 3'd7, 11'h400, 16'h0000, 1'b1, 1'b0);
      xact("sub",     16'd2,  3'd7, 3'd5, 3'd4, 11'h000, 16'h1F54, 1'b0, 1'b0);
      xact("jmp",     16'd34, 3'd0, 3'd0, 3'd0, 11'h400, 16'hCC00, 1'b0, 1'b0);
      xact("const",   16'd32, 3'd3, 3'd0, 3'd0, 11'h700, 16'h9700, 1'b0, 1'b0);
      xact("hiconst", 16'd33, 3'd2, 3'd0, 3'd0, 11'h0AB, 16'hD5AB, 1'b0, 1'b0);
      xact("sra_o",   16'd25, 3'd4, 3'd6, 3'd0, 11'h01F, 16'hA99F, 1'b0, 1'b1);
      xact("mod",     16'd4,  3'd1, 3'd2, 3'd5, 11'h000, 16'hA2B5, 1'b0, 1'b0);
      xact("cmp",     16'd16, 3'd0, 3'd6, 3'd2, 11'h000, 16'h2C02, 1'b0, 1'b0);
      xact("cmpi",    16'd18, 3'd0, 3'd1, 3'd0, 11'h7C0, 16'h2340, 1'b0, 1'b0);
      xact("xor",     16'd11, 3'd0, 3'd7, 3'd1, 11'h000, 16'h51D9, 1'b0, 1'b0);
      xact("rti",     16'd36, 3'd5, 3'd5, 3'd5, 11'h3FF, 16'h8000, 1'b0, 1'b0);
      xact("andi_o",  16'd12, 3'd2, 3'd3, 3'd0, 11'h7EF, 16'h54EF, 1'b0, 1'b1);

      // Back-pressure: A=0x1283, B=0x1F54, C=0x51D9
      i_ready = 1'b0;
      @(negedge clk);
      drive(16'd0, 3'd1, 3'd2, 3'd3, 11'h000);
      chk("bp_a_ready", {15'd0, o_ready}, 16'd1);
      @(negedge clk);
      drive(16'd2, 3'd7, 3'd5, 3'd4, 11'h000);
      chk("bp_b_ready", {15'd0, o_ready}, 16'd1);
      chk("bp_head_a", o_insn, 16'h1283);
      @(negedge clk);
      drive(16'd11, 3'd0, 3'd7, 3'd1, 11'h000);
      chk("bp_full", {15'd0, o_ready}, 16'd0);
      chk("bp_hold_a", o_insn, 16'h1283);
      @(negedge clk);
      chk("bp_still_full", {15'd0, o_ready}, 16'd0);
      chk("bp_stable_a", o_insn, 16'h1283);
      $display("xact bp stalled third word, head=%h", o_insn);
      i_ready = 1'b1;
      @(negedge clk);
      chk("bp_head_b", o_insn, 16'h1F54);
      chk("bp_ready_again", {15'd0, o_ready}, 16'd1);
      @(negedge clk);
      i_valid = 1'b0;
      chk("bp_head_c", o_insn, 16'h51D9);
      chk("bp_valid_c", {15'd0, o_valid}, 16'd1);
      @(negedge clk);
      exp_count = exp_count + 16'd3;
      chk("bp_empty", {15'd0, o_valid}, 16'd0);
      chk("bp_count", o_count, exp_count);
      $display("xact bp drained in order, count=%0d", o_count);

      // Asynchronous reset with two entries buffered
      i_ready = 1'b0;
      @(negedge clk);
      drive(16'd6, 3'd1, 3'd2, 3'd0, 11'h7FF);
      @(negedge clk);
      drive(16'd36, 3'd0, 3'd0, 3'd0, 11'h000);
      @(negedge clk);
      i_valid = 1'b0;
      chk("ar_full", {15'd0, o_ready}, 16'd0);
      chk("ar_valid_pre", {15'd0, o_valid}, 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", {15'd0, o_valid}, 16'd0);
      chk("ar_count", o_count, 16'h0000);
      chk("ar_insn", o_insn, 16'h0000);
      chk("ar_ready", {15'd0, o_ready}, 16'd0);
      $display("xact async reset: valid=%b count=%0d", o_valid, o_count);
      @(negedge clk);
      rst = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      chk("ar_post_ready", {15'd0, o_ready}, 16'd1);
      chk("ar_post_empty", {15'd0, o_valid}, 16'd0);
      exp_count = 16'd0;
      xact("after_rst", 16'd10, 3'd3, 3'd4, 3'd5, 11'h000, 16'h5715, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
